execute_pipe: RTL and testbench

EXECUTE_PIPE -- requirements
Module: execute_pipe

---
 rtl/execute_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_execute_pipe.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/execute_pipe.sv
// Multi-cycle execute stage: ALU, branches/jumps, load/store to a private data memory.
// Define EXECUTE_PIPE_MUL_EN to add the op0/fn24 shift-add multiplier (WIDTH MUL cycles).
module execute_pipe #(
  parameter int WIDTH   = 32,
  parameter int DMEM_AW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      ins,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       wra,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] nextpc,
  output logic             busy
);
  localparam int NB = WIDTH / 8;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MEM, S_MUL, S_DONE} state_t;
  state_t r_state, w_next;

  logic [31:0]      r_ins;
  logic [WIDTH-1:0] r_pc, r_a, r_b, r_result, r_nextpc, r_rdata;
  logic [4:0]       r_wra;
  logic [WIDTH-1:0] r_mem [0:(2**DMEM_AW)-1];

  logic             w_accept;
  logic [5:0]       w_op;
  logic [4:0]       w_fn, w_shamt, w_rt, w_rd, w_wr;
  logic [WIDTH-1:0] w_simm, w_seq, w_bta, w_res, w_npc, w_ea, w_eash, w_ldval;
  logic [DMEM_AW-1:0] w_addr;
  logic             w_ld, w_mul;
  logic [NB-1:0]    w_be;

  assign in_ready  = rst_n && ((r_state == S_IDLE) || (r_state == S_DONE && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign wra       = r_wra;
  assign result    = r_result;
  assign nextpc    = r_nextpc;

  assign w_op    = r_ins[31:26];
  assign w_rt    = r_ins[20:16];
  assign w_rd    = r_ins[15:11];
  assign w_shamt = r_ins[10:6];
  assign w_fn    = r_ins[4:0];
  assign w_simm  = {{(WIDTH-16){r_ins[15]}}, r_ins[15:0]};
  assign w_seq   = r_pc + 1'b1;
  assign w_bta   = w_seq + w_simm;
  assign w_ea    = r_a + w_simm;
  assign w_eash  = $signed(w_ea) >>> 2;
  assign w_addr  = w_eash[DMEM_AW-1:0];

  // Decode of the captured instruction; undefined encodings fall through to the defaults.
  always_comb begin
    w_res = '1;
    w_wr  = '0;
    w_npc = w_seq;
    w_ld  = 1'b0;
    w_mul = 1'b0;
    w_be  = '0;
    case (w_op)
      6'd0: begin
        w_wr = w_rd;
        case (w_fn)
          5'd0:  w_res = r_a + r_b;
          5'd2:  w_res = r_a - r_b;
          5'd8:  w_res = r_a & r_b;
          5'd9:  w_res = r_a | r_b;
          5'd10: w_res = r_a ^ r_b;
          5'd11: w_res = ~(r_a | r_b);
          5'd16: w_res = r_a << w_shamt;
          5'd17: w_res = r_a >> w_shamt;
          5'd18: w_res = $signed(r_a) >>> w_shamt;
`ifdef EXECUTE_PIPE_MUL_EN
          5'd24: begin w_mul = 1'b1; w_res = '0; end
`endif
          default: begin w_res = '1; w_wr = '0; end
        endcase
      end
      6'd1:  begin w_res = r_a + w_simm; w_wr = w_rt; end
      6'd3:  begin w_res = w_simm << 16;  w_wr = w_rt; end
      6'd4:  begin w_res = r_a & w_simm;  w_wr = w_rt; end
      6'd5:  begin w_res = r_a | w_simm;  w_wr = w_rt; end
      6'd6:  begin w_res = r_a ^ w_simm;  w_wr = w_rt; end
      6'd16, 6'd18, 6'd20: begin w_ld = 1'b1; w_res = '0; w_wr = w_rt; end
      6'd24: begin w_res = '0; w_be = '1; end
      6'd26: begin w_res = '0; w_be[1:0] = 2'b11; end
      6'd28: begin w_res = '0; w_be[0] = 1'b1; end
      6'd32: begin w_res = '0; w_npc = (r_a == r_b) ? w_bta : w_seq; end
      6'd33: begin w_res = '0; w_npc = (r_a != r_b) ? w_bta : w_seq; end
      6'd34: begin w_res = '0; w_npc = ($signed(r_a) <  $signed(r_b)) ? w_bta : w_seq; end
      6'd35: begin w_res = '0; w_npc = ($signed(r_a) <= $signed(r_b)) ? w_bta : w_seq; end
      6'd40: begin w_res = '0; w_npc = {{(WIDTH-26){1'b0}}, r_ins[25:0]}; end
      6'd41: begin w_res = w_seq; w_wr = 5'd31; w_npc = {{(WIDTH-26){1'b0}}, r_ins[25:0]}; end
      6'd42: begin w_res = '0; w_npc = r_a; end
      default: ;
    endcase
  end

  always_comb begin
    case (w_op)
      6'd18:   w_ldval = {{(WIDTH-16){r_rdata[15]}}, r_rdata[15:0]};
      6'd20:   w_ldval = {{(WIDTH-8){r_rdata[7]}}, r_rdata[7:0]};
      default: w_ldval = r_rdata;
    endcase
  end

`ifdef EXECUTE_PIPE_MUL_EN
  localparam int CW = $clog2(WIDTH) + 1;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, w_acc_nxt;
  logic [CW-1:0]    r_cnt;
  logic             w_mul_last;

  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_EXEC) begin
      r_mcand  <= r_a;
      r_mplier <= r_b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_MUL) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_acc_nxt;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_EXEC;
      S_EXEC: w_next = w_ld ? S_MEM : (w_mul ? S_MUL : S_DONE);
      S_MEM:  w_next = S_DONE;
`ifdef EXECUTE_PIPE_MUL_EN
      S_MUL:  if (w_mul_last) w_next = S_DONE;
`else
      S_MUL:  w_next = S_IDLE;
`endif
      S_DONE: if (out_ready) w_next = w_accept ? S_EXEC : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output registers only change before DONE, so they hold steady under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ins    <= '0;
      r_pc     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_wra    <= '0;
      r_result <= '0;
      r_nextpc <= '0;
    end else begin
      if (w_accept) begin
        r_ins <= ins;
        r_pc  <= pc;
        r_a   <= reg1;
        r_b   <= reg2;
      end
      case (r_state)
        S_EXEC: begin
          r_wra    <= w_wr;
          r_nextpc <= w_npc;
          r_result <= w_res;
        end
        S_MEM: r_result <= w_ldval;
`ifdef EXECUTE_PIPE_MUL_EN
        S_MUL: if (w_mul_last) r_result <= w_acc_nxt;
`endif
        default: ;
      endcase
    end
  end

  // Memory is never reset; an async reset leaves S_EXEC before the next edge, cancelling the store.
  always_ff @(posedge clk) begin
    if (r_state == S_EXEC) begin
      r_rdata <= r_mem[w_addr];
      for (int i = 0; i < NB; i++)
        if (w_be[i]) r_mem[w_addr][8*i +: 8] <= r_b[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_execute_pipe.sv
// Directed self-checking bench for execute_pipe (WIDTH=32).
module tb_execute_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0]  ins;
  logic [W-1:0] pc, reg1, reg2, result, nextpc;
  logic [4:0]   wra;

  int passed = 0;
  int total  = 0;
  int lat;

  execute_pipe #(.WIDTH(W), .DMEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ins(ins), .pc(pc), .reg1(reg1), .reg2(reg2),
    .out_valid(out_valid), .out_ready(out_ready),
    .wra(wra), .result(result), .nextpc(nextpc), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] sh, input logic [4:0] fn);
    return {6'd0, 5'd0, 5'd0, rd, sh, 1'b0, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
    return {op, 5'd0, rt, imm};
  endfunction
  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one instruction from IDLE (called at posedge+1) and wait for out_valid.
  task automatic issue(input string tag, input logic [31:0] i, input logic [W-1:0] p,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    ins = i; pc = p; reg1 = a; reg2 = b; in_valid = 1'b1;
    #1 chk({tag, "_rdy"}, W'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op(input string tag, input logic [31:0] i, input logic [W-1:0] p,
                    input logic [W-1:0] a, input logic [W-1:0] b, input bit cr,
                    input logic [W-1:0] er, input logic [4:0] ew, input logic [W-1:0] en, input int el);
    issue(tag, i, p, a, b);
    chk({tag, "_lat"}, W'(lat), W'(el));
    if (cr) chk({tag, "_res"}, result, er);
    chk({tag, "_wra"}, W'(wra), W'(ew));
    chk({tag, "_npc"}, nextpc, en);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ins = '0; pc = '0; reg1 = '0; reg2 = '0;
    #12;
    chk("rst_rdy",  W'(in_ready), 0);
    chk("rst_vld",  W'(out_valid), 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_wra",  W'(wra), 0);
    chk("rst_res",  result, 0);
    chk("rst_npc",  nextpc, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_rdy", W'(in_ready), 1);

    // ALU
    op("add",  rtype(3, 0, 0),  32'h100, 5, 7, 1, 12, 3, 32'h101, 2);
    op("sub",  rtype(4, 0, 2),  32'h10, 5, 7, 1, 32'hFFFF_FFFE, 4, 32'h11, 2);
    op("nor",  rtype(5, 0, 11), 0, 32'h0F0F_0000, 32'h00FF_00FF, 1, 32'hF000_FF00, 5, 1, 2);
    op("sra",  rtype(6, 4, 18), 0, 32'h8000_0010, 32'h8000_0010, 1, 32'hF800_0001, 6, 1, 2);
    op("srl",  rtype(6, 4, 17), 0, 32'h8000_0010, 32'h8000_0010, 1, 32'h0800_0001, 6, 1, 2);
    op("addi", itype(1, 5, 16'hFFFF), 0, 10, 0, 1, 9, 5, 1, 2);
    op("lui",  itype(3, 8, 16'h1234), 0, 0, 0, 1, 32'h1234_0000, 8, 1, 2);
    op("andi", itype(4, 9, 16'h8001), 0, 32'hF0F0_F0F0, 0, 1, 32'hF0F0_8000, 9, 1, 2);
    op("undef_op", itype(63, 9, 0), 32'h20, 1, 2, 1, 32'hFFFF_FFFF, 0, 32'h21, 2);
    op("undef_fn", rtype(3, 0, 31), 32'h20, 1, 2, 1, 32'hFFFF_FFFF, 0, 32'h21, 2);

    // Memory
    op("sw",   itype(24, 2, 0), 0, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 1, 2);
    op("lb",   itype(20, 7, 0), 0, 32'h10, 0, 1, 32'hFFFF_FFEF, 7, 1, 3);
    op("lh",   itype(18, 7, 4), 0, 32'h0C, 0, 1, 32'hFFFF_BEEF, 7, 1, 3);
    op("lw",   itype(16, 7, 16'hFFFC), 0, 32'h14, 0, 1, 32'hDEAD_BEEF, 7, 1, 3);
    op("sb",   itype(28, 2, 0), 0, 32'h10, 32'h0000_0011, 0, 0, 0, 1, 2);
    op("lw_sb", itype(16, 7, 0), 0, 32'h10, 0, 1, 32'hDEAD_BE11, 7, 1, 3);
    op("sh",   itype(26, 2, 0), 0, 32'h10, 32'h1234_5678, 0, 0, 0, 1, 2);
    op("lw_sh", itype(16, 7, 0), 0, 32'h10, 0, 1, 32'hDEAD_5678, 7, 1, 3);
    op("lb_pos", itype(20, 7, 0), 0, 32'h10, 0, 1, 32'h0000_0078, 7, 1, 3);

    // Branches and jumps
    op("beq",  itype(32, 0, 16'hFFFE), 4, 32'h10, 32'h10, 0, 0, 0, 3, 2);
    op("bne",  itype(33, 0, 16'hFFFE), 4, 32'h10, 32'h10, 0, 0, 0, 5, 2);
    op("blt",  itype(34, 0, 16'h0002), 4, 32'hFFFF_FFFF, 1, 0, 0, 0, 7, 2);
    op("ble",  itype(35, 0, 16'h0002), 4, 3, 3, 0, 0, 0, 7, 2);
    op("j",    jtype(40, 26'h0123456), 32'h40, 0, 0, 0, 0, 0, 32'h0012_3456, 2);
    op("jal",  jtype(41, 26'h0123456), 32'h40, 0, 0, 1, 32'h41, 31, 32'h0012_3456, 2);
    op("jr",   itype(42, 0, 0), 32'h40, 32'hABC, 0, 0, 0, 0, 32'hABC, 2);

`ifdef EXECUTE_PIPE_MUL_EN
    op("mul",  rtype(12, 0, 24), 0, 32'h0000_FFFF, 32'h0001_0001, 1, 32'hFFFF_FFFF, 12, 1, W + 2);
`else
    op("mul",  rtype(12, 0, 24), 0, 32'h0000_FFFF, 32'h0001_0001, 1, 32'hFFFF_FFFF, 0, 1, 2);
`endif

    // Backpressure: outputs hold while out_ready is low, then back-to-back issue
    out_ready = 1'b0;
    issue("bp", rtype(9, 0, 0), 32'h50, 100, 23);
    chk("bp_lat", W'(lat), 2);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_res", result, 123);
      chk("bp_hold_wra", W'(wra), 9);
      chk("bp_hold_vld", W'(out_valid), 1);
      chk("bp_hold_rdy", W'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    ins = rtype(10, 0, 2); pc = 32'h60; reg1 = 50; reg2 = 8; in_valid = 1'b1;
    #1 chk("b2b_rdy", W'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_exec_vld", W'(out_valid), 0);
    chk("b2b_busy", W'(busy), 1);
    @(posedge clk); #1;
    chk("b2b_vld", W'(out_valid), 1);
    chk("b2b_res", result, 42);
    chk("b2b_wra", W'(wra), 10);
    chk("b2b_npc", nextpc, 32'h61);
    @(posedge clk); #1;

    // Reset asserted while in MEM
    ins = itype(16, 6, 0); pc = 0; reg1 = 32'h10; reg2 = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mem_busy", W'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_vld",  W'(out_valid), 0);
    chk("mrst_busy", W'(busy), 0);
    chk("mrst_rdy",  W'(in_ready), 0);
    chk("mrst_res",  result, 0);
    chk("mrst_wra",  W'(wra), 0);
    chk("mrst_npc",  nextpc, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrel_rdy", W'(in_ready), 1);
    op("lw_after_rst", itype(16, 6, 0), 0, 32'h10, 0, 1, 32'hDEAD_5678, 6, 1, 3);
    op("add_after_rst", rtype(3, 0, 0), 32'h7, 5, 7, 1, 12, 3, 32'h8, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
